// File: rtl/pwm_capture.sv
// pwm_capture: measures PWM period (rise to rise) and high time (rise to fall) in sysclk cycles.
// Define PWM_CAPTURE_FILTER_EN to insert a 3-sample glitch filter after the synchronizer.
module pwm_capture #(
  parameter int WIDTH = 20
) (
  input  logic             sysclk,
  input  logic             reset,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] period_out,
  output logic [WIDTH-1:0] high_out,
  output logic             valid,
  output logic             timeout,
  output logic             stuck_level
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_e;

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  state_e           state_q, state_d;
  logic             s1_q, s2_q, s3_q;
  logic             lvl, rise, fall;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] high_tmp_q, high_tmp_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0] high_q, high_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;
  logic             stuck_q, stuck_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= pwm_in;
      s2_q <= s1_q;
      s3_q <= lvl;
    end
  end

`ifdef PWM_CAPTURE_FILTER_EN
  logic f1_q, f2_q;

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      f1_q <= 1'b0;
      f2_q <= 1'b0;
    end else begin
      f1_q <= s2_q;
      f2_q <= f1_q;
    end
  end

  // s3_q holds the filtered level; it follows s2 only after three matching samples.
  always_comb lvl = (s2_q == f1_q && f1_q == f2_q) ? s2_q : s3_q;
`else
  always_comb lvl = s2_q;
`endif

  assign rise = lvl & ~s3_q;
  assign fall = ~lvl & s3_q;

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      high_tmp_q <= '0;
      period_q   <= '0;
      high_q     <= '0;
      valid_q    <= 1'b0;
      timeout_q  <= 1'b0;
      stuck_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      high_tmp_q <= high_tmp_d;
      period_q   <= period_d;
      high_q     <= high_d;
      valid_q    <= valid_d;
      timeout_q  <= timeout_d;
      stuck_q    <= stuck_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no latches are inferred.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    high_tmp_d = high_tmp_q;
    period_d   = period_q;
    high_d     = high_q;
    valid_d    = 1'b0;
    timeout_d  = timeout_q;
    stuck_d    = stuck_q;
    if (state_q != IDLE && cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;

    unique case (state_q)
      IDLE: begin
        if (rise) begin
          state_d   = HIGH;
          cnt_d     = CNT_ONE;
          timeout_d = 1'b0;
        end
      end
      HIGH: begin
        if (rise) begin
          cnt_d = CNT_ONE;
        end else if (fall) begin
          state_d    = LOW;
          high_tmp_d = cnt_q;
        end else if (cnt_q == CNT_MAX) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
          stuck_d   = s2_q;
        end
      end
      LOW: begin
        // A rise on the saturation cycle still completes a normal measurement.
        if (rise) begin
          state_d  = HIGH;
          period_d = cnt_q;
          high_d   = high_tmp_q;
          valid_d  = 1'b1;
          cnt_d    = CNT_ONE;
        end else if (cnt_q == CNT_MAX) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
          stuck_d   = s2_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign period_out  = period_q;
  assign high_out    = high_q;
  assign valid       = valid_q;
  assign timeout     = timeout_q;
  assign stuck_level = stuck_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: WIDTH=8 and WIDTH=20 instances share one stimulus and
// are compared every cycle against an event/timestamp reference model.
module tb_pwm_capture;

`ifdef PWM_CAPTURE_FILTER_EN
  localparam int LAT  = 5;
  localparam bit FILT = 1'b1;
  localparam int MINP = 3;
`else
  localparam int LAT  = 3;
  localparam bit FILT = 1'b0;
  localparam int MINP = 1;
`endif

  logic        sysclk = 1'b0;
  logic        reset  = 1'b0;
  logic        pwm_in = 1'b0;
  logic [7:0]  p8, h8;
  logic [19:0] p20, h20;
  logic        v8, t8, s8, v20, t20, s20;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 sysclk = ~sysclk;

  pwm_capture #(.WIDTH(8)) u_dut8 (
    .sysclk(sysclk), .reset(reset), .pwm_in(pwm_in),
    .period_out(p8), .high_out(h8), .valid(v8), .timeout(t8), .stuck_level(s8)
  );

  pwm_capture #(.WIDTH(20)) u_dut20 (
    .sysclk(sysclk), .reset(reset), .pwm_in(pwm_in),
    .period_out(p20), .high_out(h20), .valid(v20), .timeout(t20), .stuck_level(s20)
  );

  // Reference model: timestamps of processed edges, index 0 = WIDTH 8, index 1 = WIDTH 20.
  typedef struct packed {
    int t;
    bit lv;
  } ev_t;

  ev_t evq[$];
  bit  hist [0:99999];
  bit  flt;
  int  maxv   [2] = '{255, 1048575};
  bit  m_valid[2], m_to[2], m_stuck[2], m_armed[2], m_inhigh[2];
  int  m_per  [2], m_hi[2], m_rise[2], m_htmp[2];

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_reset();
    evq.delete();
    flt = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_valid[i] = 0; m_to[i] = 0; m_stuck[i] = 0; m_armed[i] = 0; m_inhigh[i] = 0;
      m_per[i] = 0; m_hi[i] = 0; m_rise[i] = 0; m_htmp[i] = 0;
    end
  endtask

  task automatic model_edge(input int e);
    bit rise_e = 1'b0;
    bit fall_e = 1'b0;
    bit level_now;
    if (evq.size() > 0 && evq[0].t == e) begin
      ev_t ev = evq.pop_front();
      rise_e = ev.lv;
      fall_e = !ev.lv;
    end
    level_now = (e >= 3) ? hist[e-3] : 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_valid[i] = 1'b0;
      if (rise_e) begin
        if (!m_armed[i]) begin
          m_armed[i] = 1; m_inhigh[i] = 1; m_to[i] = 0;
        end else if (!m_inhigh[i]) begin
          m_valid[i] = 1;
          m_per[i]   = min2(e - m_rise[i], maxv[i]);
          m_hi[i]    = m_htmp[i];
          m_inhigh[i] = 1;
        end
        m_rise[i] = e;
      end else if (m_armed[i]) begin
        if (fall_e && m_inhigh[i]) begin
          m_htmp[i]   = min2(e - m_rise[i], maxv[i]);
          m_inhigh[i] = 0;
        end else if (e - m_rise[i] >= maxv[i]) begin
          m_armed[i] = 0; m_to[i] = 1; m_stuck[i] = level_now;
        end
      end
    end
  endtask

  // Drive one cycle of pwm_in at the falling edge, advance the model, compare at the next falling edge.
  task automatic step(input bit v);
    bit lv;
    pwm_in    = v;
    hist[cyc] = v;
    if (reset) begin
      lv = v;
      if (FILT) begin
        lv = flt;
        if (cyc >= 2 && hist[cyc-1] == v && hist[cyc-2] == v) lv = v;
      end
      if (lv != flt) begin
        ev_t ev;
        ev.t  = cyc + 3;
        ev.lv = lv;
        evq.push_back(ev);
        flt = lv;
      end
    end
    @(posedge sysclk);
    cyc++;
    if (reset) model_edge(cyc);
    else model_reset();
    @(negedge sysclk);
    checks += 10;
    if (v8 !== m_valid[0]) begin errors++; $display("FAIL valid_w8 cyc=%0d got=%b exp=%b", cyc, v8, m_valid[0]); end
    if (t8 !== m_to[0]) begin errors++; $display("FAIL timeout_w8 cyc=%0d got=%b exp=%b", cyc, t8, m_to[0]); end
    if (s8 !== m_stuck[0]) begin errors++; $display("FAIL stuck_w8 cyc=%0d got=%b exp=%b", cyc, s8, m_stuck[0]); end
    if (p8 !== 8'(m_per[0])) begin errors++; $display("FAIL period_w8 cyc=%0d got=%0d exp=%0d", cyc, p8, m_per[0]); end
    if (h8 !== 8'(m_hi[0])) begin errors++; $display("FAIL high_w8 cyc=%0d got=%0d exp=%0d", cyc, h8, m_hi[0]); end
    if (v20 !== m_valid[1]) begin errors++; $display("FAIL valid_w20 cyc=%0d got=%b exp=%b", cyc, v20, m_valid[1]); end
    if (t20 !== m_to[1]) begin errors++; $display("FAIL timeout_w20 cyc=%0d got=%b exp=%b", cyc, t20, m_to[1]); end
    if (s20 !== m_stuck[1]) begin errors++; $display("FAIL stuck_w20 cyc=%0d got=%b exp=%b", cyc, s20, m_stuck[1]); end
    if (p20 !== 20'(m_per[1])) begin errors++; $display("FAIL period_w20 cyc=%0d got=%0d exp=%0d", cyc, p20, m_per[1]); end
    if (h20 !== 20'(m_hi[1])) begin errors++; $display("FAIL high_w20 cyc=%0d got=%0d exp=%0d", cyc, h20, m_hi[1]); end
  endtask

  task automatic test_reset();
    model_reset();
    #1;
    checks++;
    if ({p8, h8, v8, t8, s8, p20, h20, v20, t20, s20} !== '0) begin
      errors++; $display("FAIL reset_outputs got=%h exp=0", {p8, h8, v8, t8, s8, p20, h20, v20, t20, s20});
    end
    @(negedge sysclk);
    repeat (4) step(1'b0);
    reset = 1'b1;
    repeat (5) step(1'b0);
  endtask

  task automatic test_basic();
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < 100; c++) begin
        step(c < 30);
        if (c == LAT - 2) begin
          checks++;
          if (v20 !== 1'b0) begin errors++; $display("FAIL basic_early_valid rise=%0d got=%b exp=0", k, v20); end
        end
        if (c == LAT - 1) begin
          checks++;
          if (v20 !== (k > 0)) begin errors++; $display("FAIL basic_latency rise=%0d got=%b exp=%b", k, v20, k > 0); end
        end
      end
    end
    checks++;
    if (p20 !== 20'd100 || h20 !== 20'd30) begin
      errors++; $display("FAIL basic_values got=%0d/%0d exp=100/30", p20, h20);
    end
  endtask

  task automatic test_timeout();
    repeat (5) step(1'b0);
    for (int c = 0; c < 300; c++) begin
      step(1'b1);
      if (c == LAT + 253) begin
        checks++;
        if (t8 !== 1'b0) begin errors++; $display("FAIL timeout_early got=%b exp=0", t8); end
      end
      if (c == LAT + 254) begin
        checks++;
        if (t8 !== 1'b1 || s8 !== 1'b1) begin errors++; $display("FAIL timeout_set got=%b%b exp=11", t8, s8); end
      end
    end
    repeat (20) step(1'b0);
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 50; c++) begin
        step(c < 20);
        if (c == LAT - 1) begin
          checks++;
          if (t8 !== 1'b0 || v8 !== (k == 1)) begin
            errors++; $display("FAIL timeout_rearm rise=%0d got=%b%b exp=0%b", k, t8, v8, k == 1);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    repeat (10) step(1'b0);
    repeat (10) step(1'b1);
    #3 reset = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({p8, h8, v8, t8, s8, p20, h20, v20, t20, s20} !== '0) begin
      errors++; $display("FAIL reset_mid_outputs got=%h exp=0", {p8, h8, v8, t8, s8, p20, h20, v20, t20, s20});
    end
    @(negedge sysclk);
    repeat (4) step(1'b0);
    reset = 1'b1;
    repeat (5) step(1'b0);
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 50; c++) begin
        step(c < 20);
        if (c == LAT - 1) begin
          checks++;
          if (v20 !== (k == 1)) begin errors++; $display("FAIL reset_mid_valid rise=%0d got=%b exp=%b", k, v20, k == 1); end
        end
      end
    end
    checks++;
    if (p20 !== 20'd50 || h20 !== 20'd20) begin
      errors++; $display("FAIL reset_mid_values got=%0d/%0d exp=50/20", p20, h20);
    end
  endtask

`ifndef PWM_CAPTURE_FILTER_EN
  task automatic test_narrow();
    repeat (4) for (int c = 0; c < 10; c++) step(c < 1);
    checks++;
    if (p20 !== 20'd10 || h20 !== 20'd1 || p8 !== 8'd10 || h8 !== 8'd1) begin
      errors++; $display("FAIL narrow_pulse got=%0d/%0d exp=10/1", p20, h20);
    end
  endtask
`else
  task automatic test_filter_glitch();
    repeat (10) step(1'b0);
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < 100; c++) begin
        step(c < 40 || c == 70 || c == 71);
        if (c == LAT - 1 && k > 0) begin
          checks++;
          if (v20 !== 1'b1) begin errors++; $display("FAIL filter_latency rise=%0d got=%b exp=1", k, v20); end
        end
      end
    end
    checks++;
    if (p20 !== 20'd100 || h20 !== 20'd40) begin
      errors++; $display("FAIL filter_values got=%0d/%0d exp=100/40", p20, h20);
    end
  endtask
`endif

  task automatic test_sat_edge();
    repeat (300) step(1'b0);
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 255; c++) step(c < 100);
    end
    for (int c = 0; c < LAT; c++) step(1'b1);
    checks++;
    if (v8 !== 1'b1 || p8 !== 8'd255 || t8 !== 1'b0) begin
      errors++; $display("FAIL sat_edge got=v%b p%0d t%b exp=v1 p255 t0", v8, p8, t8);
    end
    repeat (20) step(1'b1);
    repeat (20) step(1'b0);
  endtask

  task automatic test_random();
    int hi, lo;
    for (int n = 0; n < 25; n++) begin
      hi = $urandom_range(60, MINP);
      lo = ($urandom_range(5, 0) == 0) ? $urandom_range(280, 240) : $urandom_range(60, MINP);
      repeat (hi) step(1'b1);
      repeat (lo) step(1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_reset_mid();
`ifndef PWM_CAPTURE_FILTER_EN
    test_narrow();
`else
    test_filter_glitch();
`endif
    test_sat_edge();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
